// File: rtl/game_sequencer.sv
// Endless-runner game core: scrolls an 8-cell obstacle map toward the player
// once per game step, handles jumping and collisions, and keeps the score.
module game_sequencer #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned JUMP_STEPS = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_jump,
  output logic [15:0] map,
  output logic        start,
  output logic        jump,
  output logic        dead,
  output logic [31:0] score,
  output logic        step
);

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    JUMP_LOAD = 4'(JUMP_STEPS);
  localparam logic [31:0]   SCORE_MAX = 32'd99_999_999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t        state_r;
  logic [TW-1:0] tick_r;
  logic [3:0]    jcnt_r;
  logic [15:0]   lfsr_r;
  logic          start_prev_r;
  logic          jump_prev_r;

  logic          start_rise_s;
  logic          jump_rise_s;
  logic          tick_wrap_s;
  logic          jump_grant_s;
  logic          jump_eff_s;
  logic          collide_s;
  logic [1:0]    new_cell_s;
  logic [15:0]   map_shift_s;
  logic [31:0]   score_inc_s;

  // Taps 16,14,13,11 of a left-shifting Fibonacci LFSR.
  function automatic logic lfsr_fb(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

  function automatic logic [1:0] cell_code(input logic [2:0] sel);
    logic [1:0] c;
    case (sel)
      3'd0:    c = 2'd1;
      3'd1:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Button edges, next map cell, collision and saturated score increment.
  always_comb begin
    start_rise_s = btn_start & ~start_prev_r;
    jump_rise_s  = btn_jump & ~jump_prev_r;
    tick_wrap_s  = (tick_r == TICK_LAST);
    jump_grant_s = (state_r == ST_RUN) & jump_rise_s & ~jump;
    jump_eff_s   = jump | jump_grant_s;
    if (map[3:0] != 4'd0) begin
      new_cell_s = 2'd0;
    end else begin
      new_cell_s = cell_code(lfsr_r[2:0]);
    end
    map_shift_s = {map[13:0], new_cell_s};
    collide_s   = ((map_shift_s[15:14] == 2'd1) & ~jump_eff_s) |
                  ((map_shift_s[15:14] == 2'd2) &  jump_eff_s);
    if (score >= SCORE_MAX) begin
      score_inc_s = SCORE_MAX;
    end else begin
      score_inc_s = score + 32'd1;
    end
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      map          <= 16'd0;
      score        <= 32'd0;
      start        <= 1'b0;
      jump         <= 1'b0;
      dead         <= 1'b0;
      step         <= 1'b0;
      tick_r       <= '0;
      jcnt_r       <= 4'd0;
      lfsr_r       <= LFSR_SEED;
      start_prev_r <= 1'b1;
      jump_prev_r  <= 1'b1;
    end else begin
      start_prev_r <= btn_start;
      jump_prev_r  <= btn_jump;
      step         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_rise_s) begin
            state_r <= ST_RUN;
            start   <= 1'b1;
            dead    <= 1'b0;
            map     <= 16'd0;
            score   <= 32'd0;
            jump    <= 1'b0;
            jcnt_r  <= 4'd0;
            tick_r  <= '0;
          end
        end
        ST_RUN: begin
          tick_r <= tick_wrap_s ? '0 : tick_r + TW'(1'b1);
          if (jump_grant_s) begin
            jump   <= 1'b1;
            jcnt_r <= JUMP_LOAD;
          end
          if (tick_wrap_s) begin
            step   <= 1'b1;
            lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
            map    <= map_shift_s;
            if (collide_s) begin
              state_r <= ST_DEAD;
              dead    <= 1'b1;
              jump    <= 1'b0;
              jcnt_r  <= 4'd0;
            end else begin
              score <= score_inc_s;
              // A jump granted on this step keeps its full count.
              if (!jump_grant_s && jump) begin
                jcnt_r <= jcnt_r - 4'd1;
                if (jcnt_r == 4'd1) begin
                  jump <= 1'b0;
                end
              end
            end
          end
        end
        ST_DEAD: begin
          if (start_rise_s) begin
            state_r <= ST_IDLE;
            start   <= 1'b0;
            dead    <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          start   <= 1'b0;
          dead    <= 1'b0;
          jump    <= 1'b0;
          tick_r  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, JUMP_STEPS=3; a small
// LFSR/map model supplies the expected cells shifted in on each step.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_start;
  logic        btn_jump;
  logic [15:0] map;
  logic        start;
  logic        jump;
  logic        dead;
  logic [31:0] score;
  logic        step;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_map;
  logic [31:0] m_score;
  logic [15:0] f_map;
  logic [31:0] f_score;

  game_sequencer #(.TICK_DIV(4), .JUMP_STEPS(3), .LFSR_SEED(16'hACE1)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_jump  (btn_jump),
    .map       (map),
    .start     (start),
    .jump      (jump),
    .dead      (dead),
    .score     (score),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_cell(input logic [15:0] l, input logic [15:0] m);
    logic [1:0] c;
    case (l[2:0])
      3'd0:    c = 2'd1;
      3'd1:    c = 2'd2;
      default: c = 2'd0;
    endcase
    if (m[1:0] != 2'd0 || m[3:2] != 2'd0) c = 2'd0;
    return c;
  endfunction

  // One game step (4 cycles). jmode: 0 none, 1 jump rise mid-step, 2 jump rise on the step edge.
  task automatic do_step(input string tag, input int jmode,
                         input bit fmap, input logic [15:0] fmap_v,
                         input bit fscore, input logic [31:0] fscore_v,
                         input bit exp_dead, input bit exp_jump);
    btn_jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq({tag, ".step_lo"}, {31'd0, step}, 32'd0);
      if (i == 0 && jmode == 1) btn_jump = 1'b1;
    end
    if (jmode == 2) btn_jump = 1'b1;
    if (fmap) begin
      f_map = fmap_v;
      m_map = fmap_v;
      force dut.map = f_map;
    end
    if (fscore) begin
      f_score = fscore_v;
      m_score = fscore_v;
      force dut.score = f_score;
    end
    #1;
    if (fmap) release dut.map;
    if (fscore) release dut.score;
    m_map  = {m_map[13:0], exp_cell(m_lfsr, m_map)};
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    if (!exp_dead && m_score != 32'd99_999_999) m_score = m_score + 32'd1;
    @(negedge clk);
    check_eq({tag, ".step"},  {31'd0, step},  32'd1);
    check_eq({tag, ".map"},   {16'd0, map},   {16'd0, m_map});
    check_eq({tag, ".score"}, score,          m_score);
    check_eq({tag, ".dead"},  {31'd0, dead},  {31'd0, exp_dead});
    check_eq({tag, ".jump"},  {31'd0, jump},  {31'd0, exp_jump});
    check_eq({tag, ".start"}, {31'd0, start}, 32'd1);
    check_eq({tag, ".gap"},   {31'd0, (map[1:0] != 2'd0) && (map[3:2] != 2'd0)}, 32'd0);
  endtask

  task automatic press_start();
    btn_start = 1'b0;
    @(negedge clk);
    btn_start = 1'b1;
    @(negedge clk);
  endtask

  task automatic enter_run(input string tag);
    press_start();
    check_eq({tag, ".start"}, {31'd0, start}, 32'd1);
    check_eq({tag, ".dead"},  {31'd0, dead},  32'd0);
    check_eq({tag, ".map"},   {16'd0, map},   32'd0);
    check_eq({tag, ".score"}, score,          32'd0);
    check_eq({tag, ".jump"},  {31'd0, jump},  32'd0);
    m_map   = 16'd0;
    m_score = 32'd0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_start = 1'b1;
    btn_jump  = 1'b1;
    m_lfsr    = 16'hACE1;
    m_map     = 16'd0;
    m_score   = 32'd0;
    f_map     = 16'd0;
    f_score   = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst.map",   {16'd0, map},   32'd0);
    check_eq("rst.score", score,          32'd0);
    check_eq("rst.start", {31'd0, start}, 32'd0);
    check_eq("rst.jump",  {31'd0, jump},  32'd0);
    check_eq("rst.dead",  {31'd0, dead},  32'd0);
    check_eq("rst.step",  {31'd0, step},  32'd0);

    // Buttons held through reset must not count as rises.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("held.start", {31'd0, start}, 32'd0);
    check_eq("held.jump",  {31'd0, jump},  32'd0);
    btn_start = 1'b0;
    btn_jump  = 1'b0;
    @(negedge clk);
    btn_jump = 1'b1;
    @(negedge clk);
    check_eq("idle.jump_ignored", {31'd0, jump},  32'd0);
    check_eq("idle.start",        {31'd0, start}, 32'd0);

    // Run 1: plain scrolling, start ignored in RUN, jump timing, overhead death.
    enter_run("run1");
    for (int s = 1; s <= 5; s++) begin
      if (s == 3) btn_start = 1'b0;
      if (s == 4) btn_start = 1'b1;
      do_step($sformatf("r1s%0d", s), 0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    end
    check_eq("r1s5.score_hand", score, 32'd5);
    do_step("r1s6", 2, 1'b1, 16'h1000, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("r1s6.cell7", {30'd0, map[15:14]}, 32'd1);
    check_eq("r1s6.score_hand", score, 32'd6);
    do_step("r1s7",  0, 1'b0, 16'd0,    1'b0, 32'd0, 1'b0, 1'b1);
    do_step("r1s8",  1, 1'b0, 16'd0,    1'b0, 32'd0, 1'b0, 1'b1);
    do_step("r1s9",  0, 1'b0, 16'd0,    1'b0, 32'd0, 1'b0, 1'b0);
    do_step("r1s10", 1, 1'b0, 16'd0,    1'b0, 32'd0, 1'b0, 1'b1);
    do_step("r1s11", 0, 1'b1, 16'h2000, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("r1s11.cell7",      {30'd0, map[15:14]}, 32'd2);
    check_eq("r1s11.score_hand", score, 32'd10);

    btn_jump = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) btn_jump = 1'b1;
      check_eq("dead.step_lo", {31'd0, step}, 32'd0);
    end
    check_eq("dead.jump_ignored", {31'd0, jump}, 32'd0);

    // DEAD -> IDLE keeps the final map and score on display.
    press_start();
    check_eq("idle2.start", {31'd0, start}, 32'd0);
    check_eq("idle2.dead",  {31'd0, dead},  32'd0);
    check_eq("idle2.map",   {16'd0, map},   {16'd0, m_map});
    check_eq("idle2.score", score,          32'd10);

    // Run 2: ground obstacle without a jump; LFSR carries on from run 1.
    enter_run("run2");
    do_step("r2s1", 0, 1'b0, 16'd0,    1'b0, 32'd0, 1'b0, 1'b0);
    do_step("r2s2", 0, 1'b0, 16'd0,    1'b0, 32'd0, 1'b0, 1'b0);
    do_step("r2s3", 0, 1'b1, 16'h1000, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("r2s3.cell7",      {30'd0, map[15:14]}, 32'd1);
    check_eq("r2s3.score_hand", score, 32'd2);

    // Run 3: score saturation, then reset mid-jump on a step edge.
    press_start();
    enter_run("run3");
    do_step("r3s1", 0, 1'b0, 16'd0, 1'b0, 32'd0,          1'b0, 1'b0);
    do_step("r3s2", 0, 1'b0, 16'd0, 1'b1, 32'd99_999_999, 1'b0, 1'b0);
    check_eq("r3s2.sat_hand", score, 32'd99_999_999);
    do_step("r3s3", 0, 1'b0, 16'd0, 1'b1, 32'd99_999_998, 1'b0, 1'b0);
    check_eq("r3s3.sat_hand", score, 32'd99_999_999);
    btn_jump = 1'b0;
    @(negedge clk);
    btn_jump = 1'b1;
    @(negedge clk);
    check_eq("r3.airborne", {31'd0, jump}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst2.map",   {16'd0, map},   32'd0);
    check_eq("rst2.score", score,          32'd0);
    check_eq("rst2.start", {31'd0, start}, 32'd0);
    check_eq("rst2.jump",  {31'd0, jump},  32'd0);
    check_eq("rst2.dead",  {31'd0, dead},  32'd0);
    check_eq("rst2.step",  {31'd0, step},  32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst2.held_start", {31'd0, start}, 32'd0);

    // Run 4: LFSR restarts from the seed (0xACE1 -> overhead, then gap).
    m_lfsr = 16'hACE1;
    enter_run("run4");
    do_step("r4s1", 0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("r4s1.map_hand", {16'd0, map}, 32'h0002);
    do_step("r4s2", 0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("r4s2.map_hand", {16'd0, map}, 32'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
